// File: rtl/tb_trk_pkg.sv
// Shared definitions for the commit tracker: state encoding and default sizes.
package tb_trk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } trk_state_t;

  localparam int CNT_W_DEF      = 32;
  localparam int HIT_TARGET_DEF = 8;

endpackage

// File: rtl/tb_sat_cnt.sv
// Saturating up-counter: clear has priority, holds at all-ones instead of wrapping.
module tb_sat_cnt
  import tb_trk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/tb_commit_tracker.sv
// One-shot retirement observer: counts cycles/retirements/write-to-host hits and flags done.
// Optional cycle-budget timeout is built only when TB_COMMIT_TRACKER_TIMEOUT_EN is defined.
module tb_commit_tracker
  import tb_trk_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int          HIT_TARGET  = HIT_TARGET_DEF,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
  input  logic             tb_clk,
  input  logic             tb_rst,
  input  logic             trk_en,
  input  logic             commit_valid,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [XLEN-1:0]  tohost_pc,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] valid_ir_cycle,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] hit_cycle,
  output logic             done,
  output logic             timeout
);

  if (HIT_TARGET < 1) begin : g_bad_target
    $error("tb_commit_tracker: HIT_TARGET must be at least 1");
  end
  if (CNT_W < 2 || CNT_W > 63) begin : g_bad_width
    $error("tb_commit_tracker: CNT_W must be in 2..63");
  end
  if (TIMEOUT_CYC < 32'd2) begin : g_bad_timeout
    $error("tb_commit_tracker: TIMEOUT_CYC must be at least 2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  trk_state_t       r_state;
  trk_state_t       w_state_nxt;
  logic             r_done;
  logic [CNT_W-1:0] r_hit_cycle;
  logic             w_run;
  logic             w_hit;
  logic             w_tgt;
  logic [CNT_W-1:0] w_cyc_plus1;

  assign w_run = (r_state == RUN);
  assign w_hit = w_run && commit_valid && (commit_pc == tohost_pc);

  // Compare in 64 bits so a target wider than the counter never aliases; a saturated
  // hit counter still lets the target fire.
  assign w_tgt = w_hit &&
                 (({{(64-CNT_W){1'b0}}, hit_cnt} == 64'(HIT_TARGET - 1)) ||
                  (hit_cnt == CNT_MAX));

  assign w_cyc_plus1 = (cycle_count == CNT_MAX) ? CNT_MAX : cycle_count + 1'b1;

  tb_sat_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
    .i_clk(tb_clk), .i_clr(tb_rst), .i_inc(w_run), .o_q(cycle_count)
  );

  tb_sat_cnt #(.CNT_W(CNT_W)) u_ir_cnt (
    .i_clk(tb_clk), .i_clr(tb_rst), .i_inc(w_run && commit_valid), .o_q(valid_ir_cycle)
  );

  tb_sat_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
    .i_clk(tb_clk), .i_clr(tb_rst), .i_inc(w_hit), .o_q(hit_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (trk_en) w_state_nxt = RUN;
      RUN: begin
        if (w_tgt) begin
          w_state_nxt = DONE;
        end
`ifdef TB_COMMIT_TRACKER_TIMEOUT_EN
        else if ({{(64-CNT_W){1'b0}}, cycle_count} == 64'(TIMEOUT_CYC - 32'd1)) begin
          w_state_nxt = TIMEOUT;
        end
`endif
      end
      DONE:    w_state_nxt = DONE;
      TIMEOUT: w_state_nxt = TIMEOUT;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_hit_cycle <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_tgt) begin
        r_done      <= 1'b1;
        r_hit_cycle <= w_cyc_plus1;
      end
    end
  end

`ifdef TB_COMMIT_TRACKER_TIMEOUT_EN
  logic r_timeout;

  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      r_timeout <= 1'b0;
    end else if (w_run && (w_state_nxt == TIMEOUT)) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign done      = r_done;
  assign hit_cycle = r_hit_cycle;

endmodule

// File: tb/tb_tb_commit_tracker.sv
// Directed bench for tb_commit_tracker: a 32-bit instance (TIMEOUT_CYC=50) and a 4-bit instance.
module tb_tb_commit_tracker;
  import tb_trk_pkg::*;

  localparam logic [31:0] TOHOST = 32'h8000_0040;
  localparam logic [31:0] OTHER  = 32'h0000_0100;

  logic        tb_clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic        trk_en = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = '0;
  logic [31:0] tohost_pc = TOHOST;

  logic [31:0] a_cyc, a_ir, a_hit, a_hcyc;
  logic        a_done, a_to;
  logic [3:0]  b_cyc, b_ir, b_hit, b_hcyc;
  logic        b_done, b_to;

  int n_cmp = 0;
  int n_err = 0;

  always #5 tb_clk = ~tb_clk;

  tb_commit_tracker #(.XLEN(32), .CNT_W(32), .HIT_TARGET(8), .TIMEOUT_CYC(32'd50)) dut_a (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .trk_en(trk_en), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .tohost_pc(tohost_pc), .cycle_count(a_cyc),
    .valid_ir_cycle(a_ir), .hit_cnt(a_hit), .hit_cycle(a_hcyc), .done(a_done), .timeout(a_to)
  );

  tb_commit_tracker #(.XLEN(32), .CNT_W(4), .HIT_TARGET(8), .TIMEOUT_CYC(32'd50)) dut_b (
    .tb_clk(tb_clk), .tb_rst(tb_rst), .trk_en(trk_en), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .tohost_pc(tohost_pc), .cycle_count(b_cyc),
    .valid_ir_cycle(b_ir), .hit_cnt(b_hit), .hit_cycle(b_hcyc), .done(b_done), .timeout(b_to)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [31:0] cyc, input logic [31:0] ir,
                       input logic [31:0] hit, input logic [31:0] hcyc,
                       input logic dn, input logic to);
    chk({tag, ".cycle_count"}, a_cyc, cyc);
    chk({tag, ".valid_ir_cycle"}, a_ir, ir);
    chk({tag, ".hit_cnt"}, a_hit, hit);
    chk({tag, ".hit_cycle"}, a_hcyc, hcyc);
    chk({tag, ".done"}, {31'd0, a_done}, {31'd0, dn});
    chk({tag, ".timeout"}, {31'd0, a_to}, {31'd0, to});
  endtask

  task automatic restart();
    tb_rst = 1'b1; trk_en = 1'b0; commit_valid = 1'b0;
    tick(1);
    tb_rst = 1'b0; trk_en = 1'b1;
    tick(1);
    trk_en = 1'b0;
  endtask

  initial begin
    // Reset held 3 cycles, then 10 idle cycles with commits that must be ignored.
    tick(3);
    tb_rst = 1'b0;
    chk_a("reset", 0, 0, 0, 0, 1'b0, 1'b0);
    commit_valid = 1'b1; commit_pc = TOHOST;
    tick(10);
    chk_a("idle", 0, 0, 0, 0, 1'b0, 1'b0);
    chk("idle.state", 32'(dut_a.r_state), 32'(IDLE));

    // Enable cycle: commit present but not counted.
    trk_en = 1'b1; commit_pc = OTHER;
    tick(1);
    trk_en = 1'b0;
    chk("en.state", 32'(dut_a.r_state), 32'(RUN));
    chk_a("en", 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      commit_valid = (i % 2 == 0);
      tick(1);
    end
    chk_a("basic", 20, 10, 0, 0, 1'b0, 1'b0);

    // Pass detection: 5 non-hits then 8 back-to-back hits.
    restart();
    commit_valid = 1'b1; commit_pc = OTHER;
    tick(5);
    commit_pc = TOHOST;
    tick(7);
    chk_a("pass7", 12, 12, 7, 0, 1'b0, 1'b0);
    tick(1);
    chk_a("pass8", 13, 13, 8, 13, 1'b1, 1'b0);
    chk("pass.state", 32'(dut_a.r_state), 32'(DONE));
    trk_en = 1'b1;
    tick(5);
    trk_en = 1'b0;
    chk_a("frozen", 13, 13, 8, 13, 1'b1, 1'b0);

    // Mid-run reset after 4 hits, then hits without re-enable.
    restart();
    commit_valid = 1'b1; commit_pc = TOHOST;
    tick(4);
    chk_a("mid4", 4, 4, 4, 0, 1'b0, 1'b0);
    tb_rst = 1'b1;
    tick(1);
    tb_rst = 1'b0;
    chk_a("midrst", 0, 0, 0, 0, 1'b0, 1'b0);
    chk("midrst.state", 32'(dut_a.r_state), 32'(IDLE));
    tick(8);
    chk_a("noen", 0, 0, 0, 0, 1'b0, 1'b0);

    // Saturation on the 4-bit instance.
    restart();
    commit_valid = 1'b1; commit_pc = OTHER;
    tick(14);
    chk("sat14.cyc", {28'd0, b_cyc}, 32'd14);
    tick(6);
    chk("sat.cyc", {28'd0, b_cyc}, 32'd15);
    chk("sat.ir", {28'd0, b_ir}, 32'd15);
    chk("sat.hit", {28'd0, b_hit}, 32'd0);
    chk_a("wide20", 20, 20, 0, 0, 1'b0, 1'b0);

    // Cycle budget with no hits.
    restart();
    commit_valid = 1'b0;
    tick(60);
`ifdef TB_COMMIT_TRACKER_TIMEOUT_EN
    chk_a("tmo", 50, 0, 0, 0, 1'b0, 1'b1);
    chk("tmo.state", 32'(dut_a.r_state), 32'(TIMEOUT));
`else
    chk_a("notmo", 60, 0, 0, 0, 1'b0, 1'b0);
    chk("notmo.state", 32'(dut_a.r_state), 32'(RUN));
`endif

    // 8th hit lands on the edge where cycle_count reaches 50: done wins.
    restart();
    commit_valid = 1'b0;
    tick(42);
    commit_valid = 1'b1; commit_pc = TOHOST;
    tick(8);
    chk_a("race", 50, 8, 8, 50, 1'b1, 1'b0);
    tick(5);
    chk_a("race.frozen", 50, 8, 8, 50, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tb_commit_tracker.md
Name: tb_commit_tracker

Overview:
- Testbench-side observer that watches the core's retirement stream.
- Counts total cycles and retired instructions, and detects retirements at the write-to-host PC.
- Latches the cycle of the final write-to-host hit and raises a sticky done flag.
- Sits directly upstream of the end-of-test monitor, which waits on hit_cnt reaching HIT_TARGET and then prints the counters and the pass/fail banner.

Parameters:
- XLEN, 32, width of commit_pc and tohost_pc (matches N100_XLEN).
- CNT_W, 32, width of every counter output.
- HIT_TARGET, 8, number of write-to-host hits that ends the test.
- TIMEOUT_CYC, 32'd1000000, cycle budget before timeout (used only with the optional feature).

Ports:
- tb_clk  input  1  testbench clock.
- tb_rst  input  1  synchronous active-high reset, sampled on the rising edge of tb_clk.
- trk_en  input  1  start enable; level-sensitive, sampled each cycle.
- commit_valid  input  1  one instruction retires this cycle.
- commit_pc  input  XLEN  PC of the retiring instruction; valid only when commit_valid=1.
- tohost_pc  input  XLEN  address of the write-to-host loop instruction; treated as static while in RUN.
- cycle_count  output  CNT_W  cycles spent in RUN.
- valid_ir_cycle  output  CNT_W  instructions retired while in RUN.
- hit_cnt  output  CNT_W  write-to-host hits seen.
- hit_cycle  output  CNT_W  value of cycle_count at the HIT_TARGET-th hit.
- done  output  1  sticky; set when the hit target is reached.
- timeout  output  1  sticky; stays 0 without the optional feature.

Behaviour:
- Single clock domain.
- tb_rst=1 at an edge: state<=IDLE and all outputs<=0. Reset mid-RUN or in a terminal state discards everything; restart needs trk_en again.
- State IDLE:
  - Counters hold at 0.
  - trk_en=1 -> RUN next cycle. Commits in the trk_en cycle itself are not counted.
- State RUN, updated every edge:
  - cycle_count += 1.
  - If commit_valid: valid_ir_cycle += 1.
  - hit = commit_valid && (commit_pc == tohost_pc). If hit: hit_cnt += 1.
  - If hit and hit_cnt == HIT_TARGET-1:
    - hit_cycle <= cycle_count+1 (the counted value including this cycle).
    - done <= 1; state -> DONE.
  - All counter updates in this cycle still apply.
- State DONE: terminal.
  - All counters frozen. commit_valid and trk_en are ignored. done stays 1 until reset.
- trk_en dropping during RUN has no effect; the block is a one-shot.
- Registered outputs: every output changes only at a clock edge, so count/flag latency is one cycle after the sampled event.
- Counters saturate at all-ones (2^CNT_W-1) and never wrap. A saturated hit_cnt still allows the done check to fire.
- Repeated hits on consecutive cycles (tight write-to-host loop) each count as one hit.
- HIT_TARGET=1: the first hit moves the block to DONE, with hit_cycle equal to that cycle's count.
- Out-of-range configuration: HIT_TARGET=0 is illegal; an elaboration-time check raises $error.

Optional Feature:
- Macro: TB_COMMIT_TRACKER_TIMEOUT_EN.
- Defined:
  - In RUN, when cycle_count reaches TIMEOUT_CYC-1 without done, next state is TIMEOUT: timeout<=1, counters frozen.
  - A hit that completes the target on that same cycle takes priority: the block goes to DONE and timeout stays 0.
  - TIMEOUT is terminal until reset.
- Undefined: no TIMEOUT state is built, timeout is tied to 0, and TIMEOUT_CYC is unused.

Decomposition:
- Shared package tb_trk_pkg holds:
  - The state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2, TIMEOUT=2'd3).
  - The default CNT_W and HIT_TARGET constants.
- Sub-module tb_sat_cnt: a CNT_W-wide saturating up-counter with inc and clr inputs. It is instantiated for cycle_count, valid_ir_cycle and hit_cnt.
- The FSM, hit compare and hit_cycle latch stay in the top module.

Test Plan:
- Reset then idle: hold tb_rst for 3 cycles, trk_en=0 for 10 cycles -> all outputs 0 and state IDLE.
- Basic count: trk_en pulse, then 20 RUN cycles with commit_valid every other cycle and no hits -> cycle_count=20, valid_ir_cycle=10, hit_cnt=0, done=0.
- Pass detection: HIT_TARGET=8, tohost_pc=32'h8000_0040; in RUN, retire 5 non-hits on cycles 1-5, then 8 consecutive hits on cycles 6-13:
  - done rises after the cycle-13 edge, with hit_cnt=8, hit_cycle=13, valid_ir_cycle=13.
  - Further commits leave all values frozen.
- Mid-run reset: assert tb_rst after 4 hits -> next edge all outputs 0 and state IDLE; 8 hits without a new trk_en leave hit_cnt=0.
- Saturation: CNT_W=4, commit every cycle for 20 cycles -> cycle_count and valid_ir_cycle stick at 15, with no wrap.
- Timeout (macro defined): TIMEOUT_CYC=50, no hits -> timeout=1 and cycle_count=50, frozen. With the 8th hit landing on the cycle where cycle_count reaches 50 -> done=1, timeout=0.
